// File: rtl/haar_dwt_scheduler_if.sv
// Sample-in / coefficient-out stream bundle for the Haar DWT scheduler.
// master drives samples and out_ready; slave is the scheduler side.
interface haar_dwt_scheduler_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_level;
    logic [WIDTH-1:0] out_ca;
    logic [WIDTH-1:0] out_cd;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_level, out_ca, out_cd
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_level, out_ca, out_cd
    );
endinterface

// File: rtl/haar_dwt_scheduler.sv
// Multi-level Haar DWT sharing one butterfly; pair completes at edge N, result valid after N+1.
// Backpressure: full output slot stalls grants, a pending level-1 pair drops in_ready.
module haar_dwt_scheduler #(
    parameter int WIDTH  = 16,
    parameter int LEVELS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    haar_dwt_scheduler_if.slave     bus,
    output logic                    busy,
    output logic [15:0]             final_cnt
);
    localparam logic [1:0] LAST_LVL = 2'(LEVELS);

    logic [LEVELS-1:0] r_half;
    logic [LEVELS-1:0] r_pend;
    logic [WIDTH-1:0]  r_hold [LEVELS];
    logic [WIDTH-1:0]  r_pa   [LEVELS];
    logic [WIDTH-1:0]  r_pb   [LEVELS];
    logic              r_out_vld;
    logic [1:0]        r_out_lvl;
    logic [WIDTH-1:0]  r_out_ca;
    logic [WIDTH-1:0]  r_out_cd;
    logic [15:0]       r_final_cnt;

    logic              w_slot_free;
    logic              w_drain;
    logic              w_in_acc;
    logic [LEVELS:0]   w_pend_ext;
    logic [LEVELS-1:0] w_elig;
    logic              w_gnt_vld;
    logic [1:0]        w_gnt_idx;
    logic [LEVELS-1:0] w_gnt_oh;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_ca;
    logic [WIDTH-1:0]  w_cd;
    logic [LEVELS-1:0] w_push;
    logic [WIDTH-1:0]  w_push_dat [LEVELS];

    assign w_slot_free = !r_out_vld || bus.out_ready;
    assign w_drain     = r_out_vld && bus.out_ready;
    assign bus.in_ready = !r_pend[0] && !clear;
    assign w_in_acc    = bus.in_valid && bus.in_ready;
    // Zero above the deepest level, so the last level never waits on a successor.
    assign w_pend_ext  = {1'b0, r_pend};

    always_comb begin
        w_elig    = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = 2'd0;
        w_gnt_oh  = '0;
        for (int i = 0; i < LEVELS; i++) begin
            w_elig[i] = r_pend[i] && w_slot_free && !w_pend_ext[i+1];
            if (w_elig[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = 2'(i);
            end
        end
        for (int i = 0; i < LEVELS; i++) begin
            w_gnt_oh[i] = w_gnt_vld && (w_gnt_idx == 2'(i));
        end
    end

    assign w_a   = r_pa[w_gnt_idx];
    assign w_b   = r_pb[w_gnt_idx];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_ca  = WIDTH'(w_sum >> 1);
    assign w_cd  = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);

    // Level 1 is fed by the input stream, deeper levels by the shared butterfly's ca.
    always_comb begin
        w_push        = '0;
        w_push[0]     = w_in_acc;
        for (int i = 0; i < LEVELS; i++) begin
            w_push_dat[i] = w_ca;
        end
        w_push_dat[0] = bus.in_data;
        for (int i = 1; i < LEVELS; i++) begin
            w_push[i] = w_gnt_oh[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half      <= '0;
            r_pend      <= '0;
            for (int i = 0; i < LEVELS; i++) begin
                r_hold[i] <= '0;
                r_pa[i]   <= '0;
                r_pb[i]   <= '0;
            end
            r_out_vld   <= 1'b0;
            r_out_lvl   <= 2'd0;
            r_out_ca    <= '0;
            r_out_cd    <= '0;
            r_final_cnt <= 16'd0;
        end else if (clear) begin
            r_half    <= '0;
            r_pend    <= '0;
            r_out_vld <= 1'b0;
            r_out_lvl <= 2'd0;
            r_out_ca  <= '0;
            r_out_cd  <= '0;
        end else begin
            // A push only reaches a level whose pending flag is clear, so it never races a grant there.
            for (int i = 0; i < LEVELS; i++) begin
                if (w_gnt_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_push[i]) begin
                    if (!r_half[i]) begin
                        r_hold[i] <= w_push_dat[i];
                        r_half[i] <= 1'b1;
                    end else begin
                        r_pa[i]   <= r_hold[i];
                        r_pb[i]   <= w_push_dat[i];
                        r_pend[i] <= 1'b1;
                        r_half[i] <= 1'b0;
                    end
                end
            end
            if (w_gnt_vld) begin
                r_out_vld <= 1'b1;
                r_out_lvl <= w_gnt_idx + 2'd1;
                r_out_ca  <= w_ca;
                r_out_cd  <= w_cd;
            end else if (w_drain) begin
                r_out_vld <= 1'b0;
            end
            if (w_drain && (r_out_lvl == LAST_LVL)) begin
                r_final_cnt <= r_final_cnt + 16'd1;
            end
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_level = r_out_lvl;
    assign bus.out_ca    = r_out_ca;
    assign bus.out_cd    = r_out_cd;
    assign busy          = (|r_half) || (|r_pend) || r_out_vld;
    assign final_cnt     = r_final_cnt;
endmodule
